// File: rtl/gate_sweep_sequencer.sv
// Built-in self-test sweep for a 3-input selectable gate: drives all 48 (sel, input) vectors and checks the gate's answers.
// Build option: define SWEEP_STOP_ON_ERR_EN to end the sweep at the first failing vector and hold that vector on the outputs.
module gate_sweep_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic [2:0] sel,
  output logic       act,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [5:0] ERR_MAX   = 6'd48;

  // Golden truth table of the gate block for each legal select code.
  function automatic logic gate_ref(input logic [2:0] f, input logic [2:0] v);
    logic r;
    case (f)
      3'b001:  r = &v;
      3'b010:  r = |v;
      3'b011:  r = ^v;
      3'b100:  r = ~(&v);
      3'b101:  r = ~(|v);
      3'b110:  r = ~(^v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic [3:0]  r_wait;
  logic [2:0]  r_sel;
  logic [2:0]  r_vec;
  logic        r_act;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [5:0]  r_err_count;
  logic        r_mismatch;

  logic        w_expect;
  logic        w_fail;
  logic        w_last;
  logic [5:0]  w_err_next;

  // Compare the current sample against the golden model and compute the saturating error count.
  always_comb begin
    w_expect   = gate_ref(r_sel, r_vec);
    w_fail     = (dut_out != w_expect);
    w_last     = (r_sel == 3'b110) && (r_vec == 3'b111);
    w_err_next = r_err_count;
    if (w_fail && (r_err_count != ERR_MAX)) begin
      w_err_next = r_err_count + 6'd1;
    end else begin
      w_err_next = r_err_count;
    end
  end

  // Sweep sequencer: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait      <= 4'd0;
      r_sel       <= 3'b000;
      r_vec       <= 3'b000;
      r_act       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 6'd0;
      r_mismatch  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_WAIT;
            r_wait      <= SETTLE_LD;
            r_sel       <= 3'b001;
            r_vec       <= 3'b000;
            r_act       <= 1'b1;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err_count <= 6'd0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_err_count <= w_err_next;
            r_mismatch  <= w_fail;
`ifdef SWEEP_STOP_ON_ERR_EN
            // A failing vector stays on the gate inputs so the fault can be inspected.
            if (w_fail || w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_act   <= 1'b0;
              r_pass  <= (w_err_next == 6'd0);
              if (!w_fail) begin
                r_sel <= 3'b000;
                r_vec <= 3'b000;
              end else begin
                r_sel <= r_sel;
                r_vec <= r_vec;
              end
            end else begin
              r_wait <= SETTLE_LD;
              r_vec  <= r_vec + 3'd1;
              if (r_vec == 3'b111) begin
                r_sel <= r_sel + 3'd1;
              end else begin
                r_sel <= r_sel;
              end
            end
`else
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_act   <= 1'b0;
              r_pass  <= (w_err_next == 6'd0);
              r_sel   <= 3'b000;
              r_vec   <= 3'b000;
            end else begin
              r_wait <= SETTLE_LD;
              r_vec  <= r_vec + 3'd1;
              if (r_vec == 3'b111) begin
                r_sel <= r_sel + 3'd1;
              end else begin
                r_sel <= r_sel;
              end
            end
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_act   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in1       = r_vec[2];
  assign in2       = r_vec[1];
  assign in3       = r_vec[0];
  assign sel       = r_sel;
  assign act       = r_act;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign mismatch  = r_mismatch;

endmodule

// File: doc/gate_sweep_sequencer.md
Name: gate_sweep_sequencer

Overview:
- Stimulus/check stage that sits directly upstream of the 3-input selectable logic-gate block (AND/OR/XOR/NAND/NOR/XNOR, sel codes 3'b001..3'b110).
- On a start pulse it drives every valid sel code against all 8 input combinations (48 vectors) and samples the gate output after a programmable settle time.
- It compares each sample against an internal golden model, counts mismatches and reports pass/fail.
- Used for built-in self-test of the gate block.

Parameters:
- SETTLE, default 1, idle cycles between driving a vector and sampling dut_out. Legal range 0..15.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- dut_out  input  1  output of the gate block under test
- in1  output  1  gate input A (MSB of input combo)
- in2  output  1  gate input B
- in3  output  1  gate input C (LSB of input combo)
- sel  output  3  gate function select driven to the gate block
- act  output  1  activation to the gate block; high while a sweep is running
- busy  output  1  high from the start edge until the done cycle
- done  output  1  one-cycle pulse when the sweep ends
- pass  output  1  valid from done onward: 1 if err_count==0; held until next accepted start
- err_count  output  6  mismatch count, saturates at 48; cleared on accepted start
- mismatch  output  1  one-cycle pulse in the cycle after a failing sample

Behaviour:
- Reset (async, rst_n=0) values: in1/in2/in3=0, sel=3'b000, act=0, busy=0, done=0, pass=0, err_count=0, mismatch=0, state=IDLE, wait counter=0. Reset mid-sweep aborts immediately; no done pulse is produced.
- States: IDLE, WAIT, DONE.
- IDLE + start=1 at an edge: load sel=3'b001, {in1,in2,in3}=3'b000, act=1, busy=1, err_count=0, pass=0, wait=SETTLE, go WAIT.
- WAIT, wait!=0: decrement wait; outputs held.
- WAIT, wait==0: sample dut_out at this edge and compare with expected(sel,{in1,in2,in3}).
  - Expected values: 001 AND3, 010 OR3, 011 XOR3, 100 NAND3, 101 NOR3, 110 XNOR3.
  - On mismatch: err_count+1 (saturating) and mismatch=1 for the following cycle.
  - If vector is the last one (sel=3'b110, inputs=3'b111): go DONE.
  - Otherwise advance the vector: inputs+1; on wrap 111->000, sel+1. Reload wait=SETTLE.
- Each vector occupies SETTLE+1 cycles.
- Total time from the start edge to entering DONE is 48*(SETTLE+1) cycles.
- DONE (one cycle):
  - Outputs: done=1, busy=0, act=0, pass=(err_count==0).
  - Inputs and sel return to 0; go IDLE.
- start while busy or in DONE is ignored. start in the first IDLE cycle after DONE is accepted.
- sel codes 000 and 111 are never driven while act=1.
- err_count final value equals the exact number of failing vectors, 0..48.

Optional Feature:
- Macro SWEEP_STOP_ON_ERR_EN.
- Defined:
  - First mismatch ends the sweep: go DONE on the next edge, with pass=0 and err_count=1.
  - in1..in3 and sel stay frozen at the failing vector until the next accepted start; act drops to 0 in DONE.
  - Remaining vectors are skipped.
- Undefined: the full 48-vector sweep always runs, as described above.

Test Plan:
- Ideal gate model on dut_out, SETTLE=1, start pulse -> done exactly 96 cycles after the start edge; pass=1, err_count=0, mismatch never asserted.
- dut_out stuck at 0, SETTLE=0 -> done after 48 cycles; err_count=24 (ones of the six truth tables); pass=0.
- Model that inverts only the XOR function (sel=011) -> err_count=8; mismatch pulses only during sel=011 vectors.
- rst_n driven low at cycle 30 of a sweep -> all outputs return to reset values asynchronously, with no done pulse; a new start then gives a full clean sweep.
- start re-pulsed while busy=1 -> ignored: sweep length and vector order are unchanged, and done occurs once.
- With SWEEP_STOP_ON_ERR_EN and the model wrong only for NOR with inputs=3'b010 -> done on the edge after that sample; sel=3'b101 and inputs=3'b010 held; err_count=1, pass=0.
